// File: rtl/clkgate_ctrl_pkg.sv
// clkgate_ctrl_pkg: shared types and sizing helpers for the
// clock-gating sequencer (domain/sequencer state encodings).
package clkgate_ctrl_pkg;

  typedef enum logic [1:0] {
    DomOn    = 2'd0,
    DomDrain = 2'd1,
    DomOff   = 2'd2,
    DomWake  = 2'd3
  } dom_state_e;

  typedef enum logic [1:0] {
    SeqIdle  = 2'd0,
    SeqDrain = 2'd1,
    SeqWake  = 2'd2
  } seq_state_e;

  function automatic int cnt_width(int idle, int wake);
    int m;
    m = (idle > wake) ? idle : wake;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgate_ctrl_rr_pick.sv
// clkgate_ctrl_rr_pick: combinational round-robin picker.
// req/ptr in; one-hot gnt, binary idx, valid out.
module clkgate_ctrl_rr_pick
  import clkgate_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Requests at or above ptr win; otherwise wrap to the lowest.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    hi    = req & mask;
    pick  = (|hi) ? hi : req;
    valid = |req;
    idx   = '0;
    gnt   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        idx    = IdxW'(i);
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: sequences per-domain clock-gate enables.
// Ports: clk_i, rst_ni (sync, active-low), scanmode_i,
//   cfg_en_i/wake_req_i/idle_i [N] in; en_o/active_o [N],
//   busy_o out. en_o is registered, then ORed with scanmode_i.
module clkgate_ctrl
  import clkgate_ctrl_pkg::*;
#(
  parameter int NumDomains = 4,
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scanmode_i,
  input  logic [NumDomains-1:0] cfg_en_i,
  input  logic [NumDomains-1:0] wake_req_i,
  input  logic [NumDomains-1:0] idle_i,
  output logic [NumDomains-1:0] en_o,
  output logic [NumDomains-1:0] active_o,
  output logic                  busy_o
);

  localparam int N    = NumDomains;
  localparam int IdxW = idx_width(N);
  localparam int CntW = cnt_width(IdleCycles, WakeCycles);

  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N - 1);

  dom_state_e dom_q [N];
  dom_state_e dom_d [N];
  seq_state_e seq_q, seq_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [N-1:0]    en_q, en_d;
  logic [N-1:0]    act_q, act_d;

  logic [N-1:0]    target;
  logic [N-1:0]    wake_pend;
  logic [N-1:0]    drain_pend;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    gnt;
  logic [IdxW-1:0] arb_idx;
  logic            arb_vld;
  logic            any_wake;

  assign target = cfg_en_i | wake_req_i;

  always_comb begin
    wake_pend  = '0;
    drain_pend = '0;
    for (int i = 0; i < N; i++) begin
      wake_pend[i]  = (dom_q[i] == DomOff) & target[i];
      drain_pend[i] = (dom_q[i] == DomOn) & ~target[i];
    end
  end

  // Wakes always outrank drains for the shared counter.
  assign any_wake = |wake_pend;
  assign arb_req  = any_wake ? wake_pend : drain_pend;

  clkgate_ctrl_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req   (arb_req),
    .ptr   (rr_q),
    .gnt   (gnt),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  always_comb begin
    seq_d = seq_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    rr_d  = rr_q;
    for (int i = 0; i < N; i++) begin
      dom_d[i] = dom_q[i];
    end

    unique case (seq_q)
      SeqIdle: begin
        if (arb_vld) begin
          sel_d = arb_idx;
          cnt_d = '0;
          rr_d  = (arb_idx == LastIdx) ? '0
                : arb_idx + IdxW'(1);
          seq_d = any_wake ? SeqWake : SeqDrain;
          for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
              dom_d[i] = any_wake ? DomWake : DomDrain;
            end
          end
        end
      end
      SeqDrain: begin
        // Abort outranks completion; en_o never drops.
        if (target[sel_q]) begin
          dom_d[sel_q] = DomOn;
          seq_d        = SeqIdle;
        end else if (!idle_i[sel_q]) begin
          cnt_d = '0;
        end else if (cnt_q == IdleLast) begin
          dom_d[sel_q] = DomOff;
          seq_d        = SeqIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SeqWake: begin
        if (cnt_q == WakeLast) begin
          dom_d[sel_q] = DomOn;
          seq_d        = SeqIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        seq_d = SeqIdle;
      end
    endcase

    en_d  = '0;
    act_d = '0;
    for (int i = 0; i < N; i++) begin
      en_d[i]  = (dom_d[i] != DomOff);
      act_d[i] = (dom_d[i] == DomOn)
               | (dom_d[i] == DomDrain);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        dom_q[i] <= DomOn;
      end
      seq_q <= SeqIdle;
      cnt_q <= '0;
      sel_q <= '0;
      rr_q  <= '0;
      en_q  <= '1;
      act_q <= '1;
    end else begin
      for (int i = 0; i < N; i++) begin
        dom_q[i] <= dom_d[i];
      end
      seq_q <= seq_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      rr_q  <= rr_d;
      en_q  <= en_d;
      act_q <= act_d;
    end
  end

  // Scan override bypasses the register so test clocks run at once.
  assign en_o     = en_q | {N{scanmode_i}};
  assign active_o = act_q;
  assign busy_o   = (seq_q != SeqIdle);

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb_clkgate_ctrl: directed table + sequence bench for
// clkgate_ctrl with default parameters (4 domains, 16, 4).
module tb_clkgate_ctrl;

  typedef struct {
    logic       rst_n;
    logic [3:0] cfg;
    logic [3:0] wake;
    logic [3:0] idle;
    logic       scan;
    logic [3:0] xen;
    logic [3:0] xact;
    logic       xbusy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan;
  logic [3:0] cfg;
  logic [3:0] wake;
  logic [3:0] idle;
  logic [3:0] en;
  logic [3:0] act;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vec_t tbl [5];

  always #5 clk = ~clk;

  clkgate_ctrl #(
    .NumDomains (4),
    .IdleCycles (16),
    .WakeCycles (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scanmode_i (scan),
    .cfg_en_i   (cfg),
    .wake_req_i (wake),
    .idle_i     (idle),
    .en_o       (en),
    .active_o   (act),
    .busy_o     (busy)
  );

  task automatic chk(input string nm, input logic [3:0] xe,
                     input logic [3:0] xa, input logic xb);
    checks++;
    if (en !== xe || act !== xa || busy !== xb) begin
      errors++;
      $display("FAIL %s: got en=%h act=%h busy=%b want en=%h act=%h busy=%b",
               nm, en, act, busy, xe, xa, xb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string nm, input int n,
                     input logic [3:0] xe, input logic [3:0] xa,
                     input logic xb);
    for (int k = 0; k < n; k++) begin
      step();
      chk(nm, xe, xa, xb);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[2] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[3] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[4] = '{1'b1, 4'hD, 4'h0, 4'h2, 1'b0, 4'hF, 4'hF, 1'b1};

    rst_n = 1'b0;
    scan  = 1'b0;
    cfg   = 4'hF;
    wake  = 4'h0;
    idle  = 4'h0;

    // reset, hold, then drain grant of domain 1
    for (int i = 0; i < 5; i++) begin
      rst_n = tbl[i].rst_n;
      cfg   = tbl[i].cfg;
      wake  = tbl[i].wake;
      idle  = tbl[i].idle;
      scan  = tbl[i].scan;
      step();
      chk($sformatf("vec%0d", i), tbl[i].xen, tbl[i].xact, tbl[i].xbusy);
    end

    // drain completes 16 edges after entry
    run("drain1_hold", 15, 4'hF, 4'hF, 1'b1);
    run("drain1_off", 1, 4'hD, 4'hD, 1'b0);

    // wake domain 1: active 4 edges after en
    cfg = 4'hF;
    run("wake1_grant", 1, 4'hF, 4'hD, 1'b1);
    run("wake1_settle", 3, 4'hF, 4'hD, 1'b1);
    run("wake1_on", 1, 4'hF, 4'hF, 1'b0);

    // idle break at count 10 restarts the count
    cfg  = 4'hD;
    idle = 4'h2;
    run("brk_grant", 1, 4'hF, 4'hF, 1'b1);
    run("brk_cnt", 10, 4'hF, 4'hF, 1'b1);
    idle = 4'h0;
    run("brk_drop", 1, 4'hF, 4'hF, 1'b1);
    idle = 4'h2;
    run("brk_recount", 15, 4'hF, 4'hF, 1'b1);
    run("brk_off", 1, 4'hD, 4'hD, 1'b0);

    // abort of domain 2 drain at count 5
    cfg  = 4'h9;
    idle = 4'h4;
    run("abort_grant", 1, 4'hD, 4'hD, 1'b1);
    run("abort_cnt", 5, 4'hD, 4'hD, 1'b1);
    wake = 4'h4;
    run("abort_hit", 1, 4'hD, 4'hD, 1'b0);
    cfg  = 4'hD;
    wake = 4'h0;
    run("abort_on", 1, 4'hD, 4'hD, 1'b0);

    // set up: domain 1 on, domains 3 and 0 off, rr_ptr=1
    cfg = 4'hF;
    run("s5_w1", 4, 4'hF, 4'hD, 1'b1);
    run("s5_w1on", 1, 4'hF, 4'hF, 1'b0);
    cfg  = 4'h7;
    idle = 4'h8;
    run("s5_d3", 16, 4'hF, 4'hF, 1'b1);
    run("s5_d3off", 1, 4'h7, 4'h7, 1'b0);
    cfg  = 4'h6;
    idle = 4'h1;
    run("s5_d0", 16, 4'h7, 4'h7, 1'b1);
    run("s5_d0off", 1, 4'h6, 4'h6, 1'b0);

    // wake 3, then wake 0, then drain 1
    cfg  = 4'h4;
    wake = 4'h9;
    idle = 4'h2;
    run("s5_w3", 4, 4'hE, 4'h6, 1'b1);
    run("s5_w3on", 1, 4'hE, 4'hE, 1'b0);
    run("s5_w0", 4, 4'hF, 4'hE, 1'b1);
    run("s5_w0on", 1, 4'hF, 4'hF, 1'b0);
    run("s5_d1", 16, 4'hF, 4'hF, 1'b1);
    run("s5_d1off", 1, 4'hD, 4'hD, 1'b0);

    // scan forces en_o combinationally, active unaffected
    scan = 1'b1;
    #1;
    chk("scan_comb", 4'hF, 4'hD, 1'b0);
    run("scan_hold", 1, 4'hF, 4'hD, 1'b0);
    scan = 1'b0;
    #1;
    chk("scan_off", 4'hD, 4'hD, 1'b0);

    // reset in the middle of a drain of domain 2
    cfg = 4'h0;
    run("rst_drain", 4, 4'hD, 4'hD, 1'b1);
    rst_n = 1'b0;
    run("rst_mid", 1, 4'hF, 4'hF, 1'b0);
    rst_n = 1'b1;
    cfg   = 4'hF;
    wake  = 4'h0;
    run("rst_after", 2, 4'hF, 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
